// File: rtl/sort_pkg.sv
// -----------------------------------------------------------------------------
// sort_pkg
//   Shared definitions for the bitonic sorting path: the frame loader, the
//   compare-exchange network and the downstream unloader.
//   Contents:
//     W, N, CW          record width, records per frame, frame_count width
//     KEY_HI / KEY_LO   bit bounds of the key field inside a record
//     state_t           loader FSM encoding {FILL, PAD, HOLD}
//     sentinel_key(dir) key that sorts to the tail for the given direction
// -----------------------------------------------------------------------------
package sort_pkg;

  localparam int W      = 16;
  localparam int N      = 8;
  localparam int CW     = $clog2(N + 1);
  localparam int KEY_HI = W - 1;
  localparam int KEY_LO = W / 2;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    PAD  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Ascending frames pad with the largest key, descending with the smallest,
  // so padding always lands after every real record.
  function automatic logic [KEY_HI-KEY_LO:0] sentinel_key(input logic dir);
    logic [KEY_HI-KEY_LO:0] k;
    k = dir ? '0 : '1;
    return k;
  endfunction

endpackage

// File: rtl/sort_frame_loader.sv
// -----------------------------------------------------------------------------
// sort_frame_loader
//   Collects a serial stream of {key,info} records into one N-slot parallel
//   frame for the bitonic network. A short final set is padded with sentinel
//   records so the network always sees a full frame.
//   Ports:
//     clk, rst                   clock, synchronous active-high reset
//     in_valid/in_ready          record handshake
//     in_data [W-1:0]            record {key, info}
//     in_last                    final record of the current set
//     in_dir                     sort direction, taken with slot 0
//     frame_valid/frame_ready    frame handshake; outputs held while valid
//     frame_data [N*W-1:0]       slot i at [i*W +: W], slot 0 = first record
//     frame_dir                  direction latched for this frame
//     frame_count [CW-1:0]       number of real records, 1..N
// -----------------------------------------------------------------------------
module sort_frame_loader
  import sort_pkg::state_t;
  import sort_pkg::FILL;
  import sort_pkg::PAD;
  import sort_pkg::HOLD;
#(
  parameter int W  = sort_pkg::W,
  parameter int N  = sort_pkg::N,
  localparam int CW = $clog2(N + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_data,
  input  logic           in_last,
  input  logic           in_dir,
  output logic           frame_valid,
  input  logic           frame_ready,
  output logic [N*W-1:0] frame_data,
  output logic           frame_dir,
  output logic [CW-1:0]  frame_count
);

  // Sentinel record: extreme key for the direction, info field zero.
  function automatic logic [W-1:0] pad_record(input logic dir);
    return {{(W/2){~dir}}, {(W/2){1'b0}}};
  endfunction

  state_t        r_state;
  logic [CW-1:0] r_idx;
  logic [W-1:0]  r_slot [N];
  logic          r_dir;
  logic [CW-1:0] r_count;
  logic          r_frame_valid;
  logic          r_in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= FILL;
      r_idx         <= '0;
      r_dir         <= 1'b0;
      r_count       <= '0;
      r_frame_valid <= 1'b0;
      r_in_ready    <= 1'b1;
      for (int i = 0; i < N; i++) r_slot[i] <= '0;
    end else begin
      unique case (r_state)
        FILL: begin
          if (in_valid && r_in_ready) begin
            r_slot[r_idx] <= in_data;
            r_idx         <= r_idx + 1'b1;
            if (r_idx == '0) r_dir <= in_dir;
            // A full frame goes straight to HOLD even if in_last is set.
            if (r_idx == CW'(N - 1)) begin
              r_count       <= CW'(N);
              r_state       <= HOLD;
              r_frame_valid <= 1'b1;
              r_in_ready    <= 1'b0;
            end else if (in_last) begin
              r_count    <= r_idx + 1'b1;
              r_state    <= PAD;
              r_in_ready <= 1'b0;
            end
          end
        end
        PAD: begin
          // r_idx points at the first empty slot; fill it and all above.
          for (int i = 0; i < N; i++) begin
            if (CW'(i) >= r_idx) r_slot[i] <= pad_record(r_dir);
          end
          r_state       <= HOLD;
          r_frame_valid <= 1'b1;
        end
        HOLD: begin
          if (frame_ready) begin
            r_state       <= FILL;
            r_idx         <= '0;
            r_frame_valid <= 1'b0;
            r_in_ready    <= 1'b1;
          end
        end
        default: begin
          r_state       <= FILL;
          r_idx         <= '0;
          r_frame_valid <= 1'b0;
          r_in_ready    <= 1'b1;
        end
      endcase
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign frame_data[g*W +: W] = r_slot[g];
  end

  assign in_ready    = r_in_ready;
  assign frame_valid = r_frame_valid;
  assign frame_dir   = r_dir;
  assign frame_count = r_count;

endmodule

// File: tb/tb_sort_frame_loader.sv
module tb_sort_frame_loader;

  localparam int W  = 16;
  localparam int N  = 8;
  localparam int CW = $clog2(N + 1);

  typedef struct packed {
    logic [N*W-1:0] data;
    logic           dir;
    logic [CW-1:0]  count;
  } frm_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_data;
  logic           in_last;
  logic           in_dir;
  logic           frame_valid;
  logic           frame_ready;
  logic [N*W-1:0] frame_data;
  logic           frame_dir;
  logic [CW-1:0]  frame_count;

  sort_frame_loader dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .in_dir      (in_dir),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_data  (frame_data),
    .frame_dir   (frame_dir),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int n_frm  = 0;

  frm_t         q[$];
  logic [W-1:0] m_slot [N];
  int           m_idx = 0;
  logic         m_dir = 1'b0;

  task automatic check(input string tag, input logic [N*W-1:0] obs, input logic [N*W-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Reference frame builder: records in arrival order, sentinels after them.
  task automatic model_push(input logic [W-1:0] d, input logic l, input logic dr);
    frm_t f;
    if (m_idx == 0) m_dir = dr;
    m_slot[m_idx] = d;
    m_idx++;
    if (m_idx == N || l) begin
      for (int i = 0; i < N; i++)
        f.data[i*W +: W] = (i < m_idx) ? m_slot[i] : (m_dir ? 16'h0000 : 16'hFF00);
      f.dir   = m_dir;
      f.count = CW'(m_idx);
      q.push_back(f);
      m_idx = 0;
    end
  endtask

  // Present one record and hold it until it is taken (bounded wait).
  task automatic send(input logic [W-1:0] d, input logic l, input logic dr);
    int t;
    t = 0;
    in_valid = 1'b1; in_data = d; in_last = l; in_dir = dr;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 50) begin
        check("send_timeout", 1'b0, 1'b1);
        break;
      end
    end
    @(posedge clk); #1;
    if (t <= 50) model_push(d, l, dr);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Scoreboard: compare every accepted frame against the oldest expected one.
  always @(negedge clk) begin
    frm_t e;
    if (!rst && frame_valid && frame_ready) begin
      n_frm++;
      if (q.size() == 0) begin
        check("unexpected_frame", 1'b1, 1'b0);
      end else begin
        e = q.pop_front();
        check("frame_data", frame_data, e.data);
        check("frame_dir", frame_dir, e.dir);
        check("frame_count", frame_count, e.count);
      end
    end
  end

  initial begin
    int t;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_dir = 1'b0;
    frame_ready = 1'b1;
    tick(); tick();
    check("rst_frame_valid", frame_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_frame_data", frame_data, '0);
    check("rst_frame_count", frame_count, '0);
    rst = 1'b0;
    tick();

    // 1: full ascending frame back-to-back
    for (int i = 0; i < 8; i++) send(16'((8 - i) << 8) | 16'(i + 1), 1'b0, 1'b0);
    check("t1_valid_after_8th", frame_valid, 1'b1);
    check("t1_ready_low_hold", in_ready, 1'b0);
    check("t1_slot0", frame_data[15:0], 16'h0801);
    tick();
    check("t1_ready_back", in_ready, 1'b1);
    check("t1_valid_drop", frame_valid, 1'b0);

    // 2: short descending frame, padded
    send(16'h3311, 1'b0, 1'b1);
    send(16'h1122, 1'b0, 1'b0);
    send(16'h2233, 1'b1, 1'b0);
    check("t2_pad_no_valid", frame_valid, 1'b0);
    check("t2_pad_no_ready", in_ready, 1'b0);
    tick();
    check("t2_valid_after_pad", frame_valid, 1'b1);
    check("t2_slots3_7", frame_data[127:48], 80'h0);
    tick();

    // 3: padded ascending frame held back by frame_ready
    frame_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(16'h1000 * 16'(i + 1) + 16'h00A0, i == 4, 1'b0);
    in_valid = 1'b1; in_data = 16'hDEAD; in_dir = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("t3_hold_valid", frame_valid, 1'b1);
      check("t3_hold_ready", in_ready, 1'b0);
      check("t3_hold_data", frame_data, q[0].data);
    end
    check("t3_pad_slots", frame_data[127:80], 48'hFF00_FF00_FF00);
    check("t3_count", frame_count, 4'd5);
    in_valid = 1'b0;
    frame_ready = 1'b1;
    tick();
    check("t3_ready_after_accept", in_ready, 1'b1);

    // 4: last on the 8th record, then a single-record frame
    for (int i = 0; i < 8; i++) send(16'h0101 * 16'(i + 3), i == 7, 1'b0);
    check("t4_no_pad", frame_valid, 1'b1);
    check("t4_count8", frame_count, 4'd8);
    tick();
    send(16'h5A5A, 1'b1, 1'b1);
    tick();
    check("t4_one_count", frame_count, 4'd1);
    tick();

    // 5: gapped input, direction flips after the first record
    for (int i = 0; i < 8; i++) begin
      send(16'h0F00 - 16'(i * 'h100) + 16'(i), 1'b0, i == 0);
      tick();
    end
    tick();

    // 6: reset mid-frame discards the partial frame
    for (int i = 0; i < 4; i++) send(16'hAB00 + 16'(i), 1'b0, 1'b1);
    m_idx = 0;
    rst = 1'b1;
    tick();
    check("t6_rst_valid", frame_valid, 1'b0);
    check("t6_rst_dir", frame_dir, 1'b0);
    check("t6_rst_data", frame_data, '0);
    check("t6_rst_count", frame_count, '0);
    check("t6_rst_ready", in_ready, 1'b1);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) send(16'h7700 + 16'(i * 3), 1'b0, 1'b0);
    tick();

    t = 0;
    while (q.size() != 0 && t < 20) begin
      tick();
      t++;
    end
    check("queue_drained", q.size(), 0);
    check("frames_seen", n_frm, 7);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
